eth_tx_frame_arbiter: RTL and testbench

Shares the single TX frame-data stream between num_req_p independent frame sources (e.g. per-core TX buffers). The stream is one size/offset header word followed by payload beats, and it feeds the AXIS TX converter. Arbitration is round-robin at whole-frame granularity. Once a source is granted, its header and every payload beat pass through unbroken until the last beat is consumed.

---
 rtl/eth_tx_frame_arbiter_pkg.sv | 37 +++
 rtl/eth_tx_frame_arbiter_if.sv | 44 ++++
 rtl/eth_tx_rr_picker.sv | 34 +++
 rtl/eth_tx_frame_arbiter.sv | 136 +++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_tx_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eth_tx_frame_arbiter_pkg
// Purpose  : Shared types, header field positions and beat-count helper for
//            the TX frame arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package eth_tx_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } eth_tx_arb_state_e;

    localparam int HDR_SIZE_LSB   = 0;
    localparam int HDR_SIZE_MSB   = 15;
    localparam int HDR_SIZE_W     = HDR_SIZE_MSB - HDR_SIZE_LSB + 1;
    localparam int HDR_OFFSET_LSB = 16;
    localparam int HDR_OFFSET_MSB = 19;
    localparam int HDR_OFFSET_W   = HDR_OFFSET_MSB - HDR_OFFSET_LSB + 1;
    localparam int BEATS_W        = 17;

    // size-1 wraps in 16 bits, so size==0 yields 65536 bytes worth of beats.
    function automatic logic [BEATS_W-1:0] calc_beats(input logic [HDR_SIZE_W-1:0] size,
                                                      input int unsigned           shift);
        logic [HDR_SIZE_W-1:0] last_byte;
        last_byte = size - HDR_SIZE_W'(1);
        return {1'b0, last_byte >> shift} + BEATS_W'(1);
    endfunction

    function automatic logic [HDR_OFFSET_W-1:0] hdr_offset(input logic [63:0] word);
        return word[HDR_OFFSET_MSB:HDR_OFFSET_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: eth_tx_frame_arbiter_if
// Purpose  : Per-source request bus plus the shared frame stream toward the
//            TX converter. slave = arbiter side, master = sources/converter.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_tx_frame_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int FRAME_WORD_WIDTH = 64,
    parameter int ID_W             = $clog2(NUM_REQ)
);
    logic [NUM_REQ*FRAME_WORD_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]                  req_v_i;
    logic [NUM_REQ-1:0]                  req_yumi_o;
    logic [FRAME_WORD_WIDTH-1:0]         frame_data_o;
    logic                                frame_data_v_o;
    logic                                frame_data_yumi_i;
    logic [ID_W-1:0]                     grant_id_o;
    logic                                busy_o;

    modport slave (
        input  req_data_i,
        input  req_v_i,
        input  frame_data_yumi_i,
        output req_yumi_o,
        output frame_data_o,
        output frame_data_v_o,
        output grant_id_o,
        output busy_o
    );

    modport master (
        output req_data_i,
        output req_v_i,
        output frame_data_yumi_i,
        input  req_yumi_o,
        input  frame_data_o,
        input  frame_data_v_o,
        input  grant_id_o,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_rr_picker
// Purpose  : Combinational round-robin priority encoder: first valid source
//            at or after the pointer, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               any_v_o
);
    logic [ID_W-1:0] w_idx;

    // Walk from the farthest offset back to the pointer so the nearest wins.
    always_comb begin
        grant_o = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (valid_i[w_idx]) begin
                grant_o = w_idx;
            end
        end
    end

    assign any_v_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_arbiter
// Purpose  : Whole-frame round-robin arbiter for the shared TX frame stream.
//            Macro ETH_TX_ARB_ZERO_LEN_DROP_EN: consume size-0 headers silently.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int FRAME_WORD_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    eth_tx_frame_arbiter_if.slave bus
);
    import eth_tx_frame_arbiter_pkg::*;

    localparam int              ID_W       = $clog2(NUM_REQ);
    localparam int              BEAT_SHIFT = $clog2(AXIS_DATA_WIDTH / 8);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

    eth_tx_arb_state_e           state_q, state_d;
    logic [ID_W-1:0]             grant_q, grant_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [BEATS_W-1:0]          beats_left_q, beats_left_d;

    logic [ID_W-1:0]             w_pick_id;
    logic                        w_pick_v;
    logic [FRAME_WORD_WIDTH-1:0] w_word;
    logic [HDR_SIZE_W-1:0]       w_size;
    logic                        w_active;
    logic                        w_src_v;
    logic                        w_hdr_drop;
    logic                        w_consume;
    logic [NUM_REQ-1:0]          w_req_yumi;
    logic [ID_W-1:0]             w_next_ptr;

    eth_tx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid_i (bus.req_v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_pick_id),
        .any_v_o (w_pick_v)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                w_word = bus.req_data_i[i*FRAME_WORD_WIDTH +: FRAME_WORD_WIDTH];
            end
        end
    end

    assign w_active   = (state_q != IDLE);
    assign w_src_v    = bus.req_v_i[grant_q];
    assign w_size     = w_word[HDR_SIZE_MSB:HDR_SIZE_LSB];
    assign w_next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);

`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
    assign w_hdr_drop = (state_q == HDR) && w_src_v && (w_size == '0);
`else
    assign w_hdr_drop = 1'b0;
`endif

    // A dropped header is consumed by the arbiter itself, not by the converter.
    assign w_consume = w_hdr_drop || (w_active && bus.frame_data_yumi_i);

    always_comb begin
        w_req_yumi = '0;
        if (w_consume) begin
            w_req_yumi[grant_q] = 1'b1;
        end
    end

    assign bus.req_yumi_o     = w_req_yumi;
    assign bus.frame_data_o   = w_word;
    assign bus.frame_data_v_o = w_active && w_src_v && !w_hdr_drop;
    assign bus.grant_id_o     = grant_q;
    assign bus.busy_o         = w_active;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (w_pick_v) begin
                    grant_d = w_pick_id;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (w_hdr_drop) begin
                    state_d  = IDLE;
                    rr_ptr_d = w_next_ptr;
                end else if (bus.frame_data_yumi_i) begin
                    beats_left_d = calc_beats(w_size, BEAT_SHIFT);
                    state_d      = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (bus.frame_data_yumi_i) begin
                    beats_left_d = beats_left_q - BEATS_W'(1);
                    if (beats_left_q == BEATS_W'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = w_next_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_arbiter
// Purpose  : Randomized frame sources/sink against a frame-level reference
//            model of round-robin whole-frame arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_arbiter;
    localparam int N   = 4;
    localparam int W   = 64;
    localparam int BPB = W / 8;

    logic clk = 1'b0;
    logic reset_i;

    eth_tx_frame_arbiter_if #(.NUM_REQ(N), .FRAME_WORD_WIDTH(W)) bus ();

    eth_tx_frame_arbiter #(
        .NUM_REQ          (N),
        .AXIS_DATA_WIDTH  (W),
        .FRAME_WORD_WIDTH (W)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Source FIFOs (what each source presents) and the model's expected words.
    logic [W-1:0] src_q [N][$];
    bit           src_hdr [N][$];
    logic [W-1:0] m_q [N][$];
    int           m_frames [N];
    int           yumi_cnt [N];
    int           obs_grant_log [$];

    bit m_active;
    bit m_hdr;
    int m_src;
    int m_ptr;
    int m_left;
    int m_grant;
    int hs_cnt;

    int gap_pct       = 0;
    int yumi_pct      = 100;
    bit hold_yumi     = 1'b0;
    int force_gap_src = -1;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_beats(input int size);
        if (size == 0) return 65536 / BPB;
        return (size + BPB - 1) / BPB;
    endfunction

    function automatic bit m_pending();
        for (int i = 0; i < N; i++) if (m_frames[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_frame(input int src, input int size);
        logic [W-1:0] hdr;
        int           beats;
        hdr        = {$urandom, $urandom};
        hdr[15:0]  = 16'(size);
        src_q[src].push_back(hdr);
        src_hdr[src].push_back(1'b1);
        m_q[src].push_back(hdr);
        beats = ref_beats(size);
`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
        if (size == 0) beats = 0;
`endif
        for (int b = 0; b < beats; b++) begin
            logic [W-1:0] pw;
            pw = {$urandom, $urandom};
            src_q[src].push_back(pw);
            src_hdr[src].push_back(1'b0);
            m_q[src].push_back(pw);
        end
        m_frames[src]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            src_hdr[i].delete();
            m_q[i].delete();
            m_frames[i] = 0;
            yumi_cnt[i] = 0;
        end
        obs_grant_log.delete();
        m_active = 1'b0;
        m_hdr    = 1'b0;
        m_src    = 0;
        m_ptr    = 0;
        m_left   = 0;
        m_grant  = 0;
        hs_cnt   = 0;
    endtask

    task automatic do_reset();
        reset_i                = 1'b1;
        bus.frame_data_yumi_i  = 1'b0;
        @(posedge clk); #1;
        check_value("rst_busy", bus.busy_o, 0);
        check_value("rst_data_v", bus.frame_data_v_o, 0);
        check_value("rst_req_yumi", bus.req_yumi_o, 0);
        check_value("rst_grant_id", bus.grant_id_o, 0);
        @(posedge clk); #1;
        reset_i     = 1'b0;
        bus.req_v_i = '0;
        clear_all();
    endtask

    task automatic step();
        logic [W-1:0] w;
        logic [N-1:0] exp_yumi;
        bit           drop, exp_v, was_active, hs;
        int           sz;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                bus.req_data_i[i*W +: W] = src_q[i][0];
                bus.req_v_i[i] = 1'b1;
                if (!src_hdr[i][0] && (i == force_gap_src || $urandom_range(99) < gap_pct))
                    bus.req_v_i[i] = 1'b0;
            end else begin
                bus.req_data_i[i*W +: W] = {$urandom, $urandom};
                bus.req_v_i[i] = 1'b0;
            end
        end
        #1;
        bus.frame_data_yumi_i = bus.frame_data_v_o && !hold_yumi && ($urandom_range(99) < yumi_pct);
        #1;
        was_active = m_active;
        w    = '0;
        sz   = 0;
        drop = 1'b0;
        if (m_active && m_q[m_src].size() > 0) begin
            w  = m_q[m_src][0];
            sz = int'(w[15:0]);
        end
`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
        drop = m_active && m_hdr && (sz == 0);
`endif
        exp_v = m_active && bus.req_v_i[m_src] && !drop;
        check_value("busy", bus.busy_o, m_active);
        check_value("grant_id", bus.grant_id_o, m_grant);
        check_value("data_v", bus.frame_data_v_o, exp_v);
        if (exp_v) check_value("data", bus.frame_data_o, w);
        hs       = m_active && (drop ? bus.req_v_i[m_src] : bus.frame_data_yumi_i);
        exp_yumi = '0;
        if (hs) exp_yumi[m_src] = 1'b1;
        check_value("req_yumi", bus.req_yumi_o, exp_yumi);

        for (int i = 0; i < N; i++) begin
            if (bus.req_yumi_o[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                void'(src_hdr[i].pop_front());
                yumi_cnt[i]++;
            end
        end

        if (hs) begin
            hs_cnt++;
            if (m_hdr) begin
                obs_grant_log.push_back(int'(bus.grant_id_o));
                m_hdr  = 1'b0;
                m_left = drop ? 0 : ref_beats(sz);
            end else begin
                m_left--;
            end
            if (m_q[m_src].size() > 0) void'(m_q[m_src].pop_front());
            if (m_left == 0) begin
                m_active = 1'b0;
                m_frames[m_src]--;
                m_ptr = (m_src + 1) % N;
            end
        end else if (!was_active && m_pending()) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && m_frames[(m_ptr + k) % N] > 0) begin
                    found = 1'b1;
                    m_src = (m_ptr + k) % N;
                end
            end
            m_active = 1'b1;
            m_hdr    = 1'b1;
            m_grant  = m_src;
        end
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        while ((m_active || m_pending()) && c < max_cycles) begin
            step();
            c++;
        end
        check_value("drain_in_budget", c < max_cycles, 1);
        repeat (2) step();
    endtask

    task automatic wait_hs(input int n, input int max_cycles);
        int c;
        c = 0;
        while (hs_cnt < n && c < max_cycles) begin
            step();
            c++;
        end
        check_value("wait_hs_in_budget", c < max_cycles, 1);
    endtask

    initial begin
        int exp_seq [5];
        int t3_words;
        exp_seq = '{0, 1, 2, 3, 0};
        reset_i               = 1'b1;
        bus.req_v_i           = '0;
        bus.req_data_i        = '0;
        bus.frame_data_yumi_i = 1'b0;
        clear_all();
        do_reset();

        // Single source, two 20-byte frames back to back.
        load_frame(0, 20);
        load_frame(0, 20);
        drain(200);
        check_value("t1_src0_yumis", yumi_cnt[0], 8);

        // All sources, two 8-byte frames each.
        do_reset();
        for (int f = 0; f < 2; f++) for (int s = 0; s < N; s++) load_frame(s, 8);
        drain(400);
        check_value("t2_frames", obs_grant_log.size(), 8);
        for (int k = 0; k < 5; k++)
            if (obs_grant_log.size() > k) check_value("t2_grant_seq", obs_grant_log[k], exp_seq[k]);

        // Size boundaries, including the 16-bit wrap of size 0.
        do_reset();
        load_frame(1, 9);
        load_frame(1, 64);
        load_frame(1, 65);
        load_frame(1, 0);
        drain(20000);
`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
        t3_words = 3 + 9 + 10 + 1;
`else
        t3_words = 3 + 9 + 10 + 1 + 8192;
`endif
        check_value("t3_src1_yumis", yumi_cnt[1], t3_words);

        // Converter backpressure then source valid gap, mid-payload.
        do_reset();
        load_frame(3, 80);
        wait_hs(4, 50);
        hold_yumi = 1'b1;
        repeat (5) step();
        hold_yumi     = 1'b0;
        force_gap_src = 3;
        repeat (3) step();
        force_gap_src = -1;
        drain(200);
        check_value("t4_src3_yumis", yumi_cnt[3], 11);

        // Reset in the middle of a source-2 payload.
        do_reset();
        load_frame(2, 200);
        wait_hs(4, 50);
        check_value("t5_grant_before_rst", bus.grant_id_o, 2);
        do_reset();
        load_frame(0, 16);
        load_frame(2, 16);
        drain(200);
        check_value("t5_first_grant", (obs_grant_log.size() > 0) ? obs_grant_log[0] : -1, 0);

`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
        // Zero-length header on source 1 is swallowed.
        do_reset();
        load_frame(1, 0);
        load_frame(2, 16);
        drain(200);
        check_value("t6_src1_yumis", yumi_cnt[1], 1);
        check_value("t6_next_grant", (obs_grant_log.size() > 1) ? obs_grant_log[1] : -1, 2);
`endif

        // Random traffic with source gaps and converter backpressure.
        do_reset();
        gap_pct  = 25;
        yumi_pct = 60;
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < N; s++) begin
                int sz;
                sz = int'($urandom_range(150, 1));
`ifdef ETH_TX_ARB_ZERO_LEN_DROP_EN
                if ($urandom_range(7) == 0) sz = 0;
`endif
                load_frame(s, sz);
            end
        end
        drain(20000);
        check_value("rand_frames", obs_grant_log.size(), 6 * N);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
